pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Stall/flush controller for the 5-stage pipeline. It drives the write-enable and flush (bubble) inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three things: load-use hazards, taken branches resolved in EX, and multi-cycle data-memory accesses in MEM. It also keeps a stall-cycle performance counter and a sticky memory-timeout error flag.

## Interface
Parameters:
- REG_ADDR_W, 5, register-file address width
- MEM_TIMEOUT, 15, MEM_WAIT cycles tolerated without ack before ERROR (≥1)

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_rs, id_rt  in  REG_ADDR_W  source registers of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  REG_ADDR_W  destination of instruction in EX
- ex_branch_taken  in  1  branch in EX resolved taken
- mem_req  in  1  MEM stage issues a data-memory access this cycle
- mem_ack  in  1  data memory completes the access this cycle
- pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we  out  1  register load enables
- if_id_flush, id_ex_flush, mem_wb_flush  out  1  load a bubble (NOP) instead of data
- stall_cycles  out  16  saturating count of cycles with pc_we=0 (excluding ERROR)
- mem_timeout  out  1  sticky; set on entry to ERROR

## Operation
- FSM states: RUN, MEM_WAIT, ERROR. Enables and flushes are combinational from state and inputs. State, wait_cnt, stall_cycles and mem_timeout are registered.
- Default in RUN: all *_we=1, all flushes=0.
- Load-use hazard = ex_mem_read & ex_rd≠0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
- Priority in RUN, highest first:
  1. mem_req & !mem_ack: freeze. All *_we=0 and mem_wb_flush=1. Go to MEM_WAIT, wait_cnt←1.
  2. ex_branch_taken: pc_we=1, if_id_flush=1, id_ex_flush=1, others advance.
  3. Load-use hazard: pc_we=0, if_id_we=0, id_ex_flush=1, EX/MEM and MEM/WB advance.
- mem_req & mem_ack in the same RUN cycle: no stall.
- MEM_WAIT, no ack: freeze as above. If wait_cnt==MEM_TIMEOUT go to ERROR, else wait_cnt+1.
- MEM_WAIT, mem_ack=1: default enables, and the branch/load-use rules apply from the held ID/EX inputs. Return to RUN.
- A branch that is taken while frozen is acted on in the ack cycle. It is not lost and not acted on twice.
- ERROR: all *_we=0, mem_wb_flush=1. mem_timeout=1. Leave only on reset.
- stall_cycles: +1 on every clock where state≠ERROR and pc_we=0. Saturates at 0xFFFF.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=RUN, wait_cnt=0, stall_cycles=0, mem_timeout=0.
  - While rst_n=0, all *_we=0 and all flushes=0.
- Enables and flushes have zero-cycle latency from their inputs.
- Load-use costs exactly 1 bubble. Branch costs 2 flushed slots.
- Memory access completing N cycles after mem_req (ack in the Nth cycle) freezes for N−1 cycles.
- ERROR is entered after MEM_TIMEOUT+1 consecutive frozen cycles without ack. mem_timeout is visible on the next edge.
- Reset asserted mid-MEM_WAIT or in ERROR returns to RUN immediately. Counters and flag clear.
- rst_n deassertion is synchronized externally; the block requires only that it meets recovery time.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=3, id_rs=3, for 1 cycle → pc_we=0, if_id_we=0, id_ex_flush=1, ex_mem_we=1; stall_cycles 0→1. With ex_rd=0 instead → no stall.
- Branch + load-use same cycle: ex_branch_taken=1 and hazard → pc_we=1, if_id_flush=1, id_ex_flush=1; stall_cycles unchanged.
- Memory wait: mem_req=1, ack on the 4th cycle → 3 frozen cycles with mem_wb_flush=1, all enables 1 in the ack cycle; stall_cycles=3; state back to RUN.
- Branch during freeze: ex_branch_taken=1 held through a 3-cycle wait → no flush while frozen; one cycle with if_id_flush=id_ex_flush=1 at ack.
- Timeout: MEM_TIMEOUT=15, mem_req=1, mem_ack=0 held → 16 frozen cycles, then ERROR with mem_timeout=1. A late mem_ack has no effect.
- Reset: assert rst_n=0 in ERROR mid-cycle → outputs immediately *_we=0, flushes 0; after release, state RUN, stall_cycles=0, mem_timeout=0. Separately, force 70000 stall cycles → stall_cycles holds at 0xFFFF.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline.
// Handles load-use, taken branches and multi-cycle MEM accesses.
module pipeline_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ack,
  output logic                  pc_we,
  output logic                  if_id_we,
  output logic                  id_ex_we,
  output logic                  ex_mem_we,
  output logic                  mem_wb_we,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  mem_wb_flush,
  output logic [15:0]           stall_cycles,
  output logic                  mem_timeout
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TO = CW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] wait_cnt, wait_nx;
  logic          hazard, freeze, br_act, lu_act;

  always_comb begin
    hazard = ex_mem_read && (ex_rd != '0) &&
             ((ex_rd == id_rs) ||
              (id_uses_rt && (ex_rd == id_rt)));
    state_nx = state;
    wait_nx  = wait_cnt;
    freeze   = 1'b0;
    br_act   = 1'b0;
    lu_act   = 1'b0;
    unique case (state)
      RUN: begin
        if (mem_req && !mem_ack) begin
          freeze   = 1'b1;
          state_nx = MEM_WAIT;
          wait_nx  = CW'(1);
        end else begin
          br_act = ex_branch_taken;
          lu_act = !ex_branch_taken && hazard;
        end
      end
      MEM_WAIT: begin
        if (!mem_ack) begin
          freeze = 1'b1;
          if (wait_cnt == TO) state_nx = ERROR;
          else wait_nx = wait_cnt + CW'(1);
        end else begin
          state_nx = RUN;
          wait_nx  = '0;
          br_act   = ex_branch_taken;
          lu_act   = !ex_branch_taken && hazard;
        end
      end
      ERROR: freeze = 1'b1;
      default: begin
        freeze   = 1'b1;
        state_nx = RUN;
      end
    endcase
  end

  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    id_ex_we     = 1'b1;
    ex_mem_we    = 1'b1;
    mem_wb_we    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    if (!rst_n) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_we  = 1'b0;
      ex_mem_we = 1'b0;
      mem_wb_we = 1'b0;
    end else if (freeze) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      mem_wb_we    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (br_act) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (lu_act) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      wait_cnt     <= '0;
      stall_cycles <= '0;
      mem_timeout  <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      if (state_nx == ERROR) mem_timeout <= 1'b1;
      if (state != ERROR && !pc_we && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl.
// Driver queues hand-computed expectations; monitor checks per cycle.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic       id_uses_rt = 0, ex_mem_read = 0, ex_branch_taken = 0;
  logic       mem_req = 0, mem_ack = 0;
  logic       pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic       if_id_flush, id_ex_flush, mem_wb_flush;
  logic [15:0] stall_cycles;
  logic       mem_timeout;

  pipeline_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
    .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush),
    .stall_cycles(stall_cycles), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  we;
    logic [2:0]  fl;
    logic [15:0] sc;
    logic        to;
  } exp_t;

  localparam logic [4:0] W_ALL = 5'b11111;
  localparam logic [4:0] W_LU  = 5'b00111;
  localparam logic [4:0] W_NO  = 5'b00000;
  localparam logic [2:0] F_NO  = 3'b000;
  localparam logic [2:0] F_BR  = 3'b110;
  localparam logic [2:0] F_LU  = 3'b010;
  localparam logic [2:0] F_FZ  = 3'b001;

  exp_t q[$];
  int   idq[$];
  int   vid = 0;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic step(
    input logic rn, input logic [4:0] rs, input logic [4:0] rt,
    input logic urt, input logic mr, input logic [4:0] rd,
    input logic br, input logic req, input logic ack,
    input logic [4:0] we, input logic [2:0] fl,
    input logic [15:0] sc, input logic to);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rn; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    ex_mem_read = mr; ex_rd = rd; ex_branch_taken = br;
    mem_req = req; mem_ack = ack;
    e.we = we; e.fl = fl; e.sc = sc; e.to = to;
    q.push_back(e);
    idq.push_back(vid);
    vid++;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e, g;
      int   id;
      e  = q.pop_front();
      id = idq.pop_front();
      g.we = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we};
      g.fl = {if_id_flush, id_ex_flush, mem_wb_flush};
      g.sc = stall_cycles;
      g.to = mem_timeout;
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL vec%0d: got we=%b fl=%b sc=%0d to=%b, exp we=%b fl=%b sc=%0d to=%b",
                 id, g.we, g.fl, g.sc, g.to, e.we, e.fl, e.sc, e.to);
      end
    end
  end

  initial begin
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, W_NO,  F_NO, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, W_ALL, F_NO, 0, 0);
    step(1, 3, 0, 0, 1, 3, 0, 0, 0, W_LU,  F_LU, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0, 0, 0, W_ALL, F_NO, 1, 0);
    step(1, 1, 5, 1, 1, 5, 0, 0, 0, W_LU,  F_LU, 1, 0);
    step(1, 1, 5, 0, 1, 5, 0, 0, 0, W_ALL, F_NO, 2, 0);
    step(1, 3, 0, 0, 1, 3, 1, 0, 0, W_ALL, F_BR, 2, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, W_ALL, F_NO, 2, 0);
    // ack in the 4th cycle: three frozen cycles
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, W_NO,  F_FZ, 2, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, W_NO,  F_FZ, 3, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, W_NO,  F_FZ, 4, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, W_ALL, F_NO, 5, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, W_ALL, F_NO, 5, 0);
    // branch held through a freeze
    step(1, 0, 0, 0, 0, 0, 1, 1, 0, W_NO,  F_FZ, 5, 0);
    step(1, 0, 0, 0, 0, 0, 1, 1, 0, W_NO,  F_FZ, 6, 0);
    step(1, 0, 0, 0, 0, 0, 1, 1, 0, W_NO,  F_FZ, 7, 0);
    step(1, 0, 0, 0, 0, 0, 1, 1, 1, W_ALL, F_BR, 8, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, W_ALL, F_NO, 8, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, W_ALL, F_NO, 8, 0);
    // load-use resolved in the ack cycle
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, W_NO,  F_FZ, 8, 0);
    step(1, 3, 0, 0, 1, 3, 0, 1, 1, W_LU,  F_LU, 9, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, W_ALL, F_NO, 10, 0);
    for (int i = 0; i < 16; i++)
      step(1, 0, 0, 0, 0, 0, 0, 1, 0, W_NO, F_FZ, 16'(10 + i), 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, W_NO, F_FZ, 26, 1);
    step(1, 3, 0, 0, 1, 3, 1, 0, 1, W_NO, F_FZ, 26, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, W_NO, F_FZ, 26, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, W_NO, F_NO, 0, 0);
    step(0, 3, 0, 0, 1, 3, 1, 1, 0, W_NO, F_NO, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, W_ALL, F_NO, 0, 0);
    step(1, 3, 0, 0, 1, 3, 0, 0, 0, W_LU,  F_LU, 0, 0);
    for (int i = 0; i < 70000; i++)
      step(1, 3, 0, 0, 1, 3, 0, 0, 0, W_LU, F_LU,
           (i + 1 > 65535) ? 16'hFFFF : 16'(i + 1), 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, W_ALL, F_NO, 16'hFFFF, 0);
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, exp 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
